// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit adder/subtractor split into STAGES equal chunks.
// One chunk is summed per pipeline stage and the carry ripples from stage to
// stage. A valid/ready handshake with full backpressure lets the whole pipe
// freeze when the consumer is not accepting. rst_n asserts asynchronously;
// its deassertion is expected to be synchronous to clk.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  // Pipeline advance: the whole pipe moves unless the output is held.
  logic adv;

  // Stage inputs: what stage k sees this cycle (stage 0 sees the ports).
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             cy_in [STAGES];
  logic             v_in  [STAGES];

  // Next-state and registered state of every stage.
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             cy_d  [STAGES];
  logic             vld_d [STAGES];
  logic             ov_d;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             cy_q  [STAGES];
  logic             vld_q [STAGES];
  logic             ov_q;

  // Chunk adder result: CW sum bits plus the carry into the next chunk.
  logic [CW:0] part;

  assign adv       = !vld_q[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign sum       = s_q[LAST];
  assign carry_out = cy_q[LAST];
  assign overflow  = ov_q;

  // Route each stage's operands: stage 0 takes the effective port operands,
  // later stages take the previous stage's registers.
  always_comb begin
    a_in[0]  = a;
    b_in[0]  = sub ? ~b : b;
    s_in[0]  = {WIDTH{1'b0}};
    cy_in[0] = sub ? 1'b1 : c;
    v_in[0]  = in_valid && adv;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]  = a_q[k-1];
      b_in[k]  = b_q[k-1];
      s_in[k]  = s_q[k-1];
      cy_in[k] = cy_q[k-1];
      v_in[k]  = vld_q[k-1];
    end
  end

  // Add chunk k in stage k; earlier sum chunks and untouched operand chunks
  // pass through. Overflow is formed where the MSB chunk is summed.
  always_comb begin
    part = {(CW+1){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
           + {{CW{1'b0}}, cy_in[k]};
      s_d[k]              = s_in[k];
      s_d[k][k*CW +: CW]  = part[CW-1:0];
      cy_d[k]             = part[CW];
      a_d[k]              = a_in[k];
      b_d[k]              = b_in[k];
      vld_d[k]            = v_in[k];
    end
    ov_d = (a_in[LAST][MSB] == b_in[LAST][MSB]) && (s_d[LAST][MSB] != a_in[LAST][MSB]);
  end

  // Stage registers: cleared on reset, loaded only when the pipe advances so
  // a stalled output (and everything behind it) holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        s_q[k]   <= {WIDTH{1'b0}};
        cy_q[k]  <= 1'b0;
        vld_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        cy_q[k]  <= cy_d[k];
        vld_q[k] <= vld_d[k];
      end
      ov_q <= ov_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder (WIDTH=16, STAGES=4): directed and random
// operations checked against an arithmetic reference model and a scoreboard.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  logic         rdy_dir;
  logic         rand_rdy;
  logic         rnd_bit = 1'b1;

  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  int           last_acc    = 0;
  int           first_acc   = 0;

  // Expected results {overflow, carry_out, sum} in acceptance order.
  logic [W+1:0] exp_q [$];
  int           out_cyc_q [$];
  logic [W+1:0] chk_e;
  logic [W+1:0] front_e;

  assign out_ready = rand_rdy ? rnd_bit : rdy_dir;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    rnd_bit <= ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as written.
  function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic fc, input logic fs);
    longint ua, ub, sa, sb, full, sr;
    logic   co, ov;
    ua = longint'(fa);
    ub = longint'(fb);
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    if (fs) begin
      full = ua - ub;
      co   = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + longint'(fc);
      co   = full[W];
      sr   = sa + sb + longint'(fc);
    end
    ov = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
    return {ov, co, full[W-1:0]};
  endfunction

  // Scoreboard: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        chk_e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(chk_e[W-1:0]));
        chk("carry_out", 32'(carry_out), 32'(chk_e[W]));
        chk("overflow", 32'(overflow), 32'(chk_e[W+1]));
        out_cyc_q.push_back(cyc);
      end
    end
  end

  // Offer one operation; returns just after the edge that accepted it.
  task automatic send_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic ts, input logic use_exp, input logic [W+1:0] texp);
    bit ok;
    ok = 1'b0;
    a = ta; b = tb_; c = tc; sub = ts; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(use_exp ? texp : model(ta, tb_, tc, ts));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    last_acc = cyc;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      input logic ts);
    send_op(ta, tb_, tc, ts, 1'b0, {(W+2){1'b0}});
  endtask

  task automatic send_x(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [W+1:0] texp);
    send_op(ta, tb_, tc, ts, 1'b1, texp);
  endtask

  task automatic send_rand();
    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Wait until every expected result has left, then confirm the pipe is idle.
  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Safety net against a hung run.
  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = 1'b0; sub = 1'b0;
    rdy_dir = 1'b1; rand_rdy = 1'b0;
    #1 rst_n = 1'b0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_sum", 32'(sum), 32'd0);
    end
    @(posedge clk);
    #1;

    // Carry ripple across all chunks, with latency check.
    out_cyc_q.delete();
    send_x(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    first_acc = last_acc;
    drain();
    chk("ripple_count", 32'(out_cyc_q.size()), 32'd1);
    chk("ripple_latency", 32'((out_cyc_q.size() != 0) ? out_cyc_q[0] - first_acc : -1),
        32'(S - 1));
    send_x(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    drain();

    // Subtract, including borrow and signed overflow.
    send_x(16'd5, 16'd9, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFC});
    send_x(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    drain();

    // Back-to-back throughput.
    out_cyc_q.delete();
    for (int i = 0; i < 20; i++) begin
      send(W'(i), W'(3 * i), 1'(i), 1'b0);
      if (i == 0) first_acc = last_acc;
    end
    drain();
    chk("b2b_count", 32'(out_cyc_q.size()), 32'd20);
    chk("b2b_latency", 32'((out_cyc_q.size() != 0) ? out_cyc_q[0] - first_acc : -1),
        32'(S - 1));
    chk("b2b_span", 32'((out_cyc_q.size() == 20) ? out_cyc_q[19] - out_cyc_q[0] : -1),
        32'd19);

    // Backpressure mid-stream.
    for (int i = 0; i < 4; i++) send_rand();
    rdy_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      front_e = (exp_q.size() != 0) ? exp_q[0] : {(W+2){1'b1}};
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_sum", 32'(sum), 32'(front_e[W-1:0]));
      chk("stall_carry", 32'(carry_out), 32'(front_e[W]));
      chk("stall_overflow", 32'(overflow), 32'(front_e[W+1]));
    end
    @(posedge clk);
    #1;
    rdy_dir = 1'b1;
    for (int i = 0; i < 4; i++) send_rand();
    drain();

    // Random operations with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) send_rand();
    @(posedge clk);
    #1;
    rand_rdy = 1'b0;
    drain();

    // Reset while operations are in flight.
    for (int i = 0; i < 3; i++) send_rand();
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_carry", 32'(carry_out), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send_x(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
